adder_arbiter: RTL and testbench

- Round-robin controller that shares one 18-bit combinational adder between two requesters.
- Grants one requester, latches its operands into the adder input registers, waits one cycle for the ripple chain to settle, then captures the 19-bit sum.
- Returns the sum to the owner with a one-cycle done pulse.
- Sits between the adder instance (sum out = carry plus WIDTH bits) and the two datapath clients that need additions.

---
 rtl/adder_arbiter.sv | 95 +++++++++
 tb/tb_adder_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// Round-robin owner of a shared registered-input adder: grants one of two requesters,
// feeds its operands to the adder, captures the WIDTH+1-bit sum and pulses done to the owner.
module adder_arbiter #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             done0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             done1,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH:0]   add_sum,
    output logic [WIDTH:0]   result,
    output logic             busy
);

    // Handshake: req is a level sampled only on the edge leaving IDLE; operands are
    // taken on that same edge, gnt pulses in LOAD and done pulses in DONE for the owner.
    typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;

    state_t             state_q, state_d;
    logic               rr_q, rr_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic [WIDTH:0]     result_q, result_d;
    logic               grant_sel;

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        owner_d   = owner_q;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        result_d  = result_q;
        grant_sel = (req0 && req1) ? rr_q : req1;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    owner_d = grant_sel;
                    add_a_d = grant_sel ? a1 : a0;
                    add_b_d = grant_sel ? b1 : b0;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = ADD;
            ADD: begin
                // Full WIDTH+1 bits so the carry-out is kept.
                result_d = add_sum;
                state_d  = DONE;
            end
            DONE: begin
                rr_d    = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            owner_q  <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            owner_q  <= owner_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            result_q <= result_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign gnt0   = (state_q == LOAD) && !owner_q;
    assign gnt1   = (state_q == LOAD) &&  owner_q;
    assign done0  = (state_q == DONE) && !owner_q;
    assign done1  = (state_q == DONE) &&  owner_q;
    assign add_a  = add_a_q;
    assign add_b  = add_b_q;
    assign result = result_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed scenarios plus random traffic, checked every cycle
// against a transaction-level model and an expected-sum queue.
module tb_adder_arbiter;
    localparam int W = 18;
    localparam logic [W-1:0] MAXV = {W{1'b1}};

    logic           clk = 1'b0;
    logic           resetn = 1'b0;
    logic           req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0]   a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic           gnt0, gnt1, done0, done1, busy;
    logic [W-1:0]   add_a, add_b;
    logic [W:0]     add_sum, result;

    int vectors = 0;
    int errors  = 0;

    adder_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn),
        .req0(req0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .result(result), .busy(busy)
    );

    // The shared combinational adder the controller drives.
    assign add_sum = {1'b0, add_a} + {1'b0, add_b};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an operation is an "age" 1..3 after its grant edge
    // (1 = grant visible, 3 = done visible); age 0 means free.
    int           m_age = 0;
    logic         m_who = 1'b0, m_prio = 1'b0;
    logic [W-1:0] m_a = '0, m_b = '0;
    logic [W:0]   m_sum = '0, m_result = '0;
    logic [W:0]   exp_q[$];

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_age = 0; m_who = 1'b0; m_prio = 1'b0;
            m_a = '0; m_b = '0; m_result = '0;
            exp_q.delete();
        end else if (m_age != 0) begin
            if (m_age == 2) m_result = m_sum;
            if (m_age == 3) begin
                m_prio = ~m_who;
                m_age  = 0;
            end else begin
                m_age++;
            end
        end else if (req0 || req1) begin
            m_who = (req0 && req1) ? m_prio : req1;
            m_a   = m_who ? a1 : a0;
            m_b   = m_who ? b1 : b0;
            m_sum = {1'b0, m_a} + {1'b0, m_b};
            exp_q.push_back(m_sum);
            m_age = 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        check("gnt0",  32'(gnt0),  32'(m_age == 1 && !m_who));
        check("gnt1",  32'(gnt1),  32'(m_age == 1 &&  m_who));
        check("done0", 32'(done0), 32'(m_age == 3 && !m_who));
        check("done1", 32'(done1), 32'(m_age == 3 &&  m_who));
        check("busy",  32'(busy),  32'(m_age != 0));
        check("add_a", 32'(add_a), 32'(m_a));
        check("add_b", 32'(add_b), 32'(m_b));
        check("result", 32'(result), 32'(m_result));
        if (done0 || done1) begin
            if (exp_q.size() == 0) check("sb_unexpected_done", 32'(1), 32'(0));
            else check("sb_result", 32'(result), 32'(exp_q.pop_front()));
        end
    end

    function automatic logic sig(input int sel);
        case (sel)
            0: return gnt0;
            1: return gnt1;
            2: return done0;
            3: return done1;
            default: return gnt0 || gnt1;
        endcase
    endfunction

    // Returns on the negedge where the selected signal is seen high.
    task automatic wait_for(input int sel, input int budget, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(sel) && n < budget);
        if (!sig(sel)) check(tag, 32'(0), 32'(1));
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        resetn = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return MAXV;
            default: return W'($urandom_range(0, 32'(MAXV)));
        endcase
    endfunction

    int gnt0_seen;

    initial begin
        do_reset();
        step(1);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_result", 32'(result), 32'(0));

        // Single request from requester 0.
        a0 = 18'd5; b0 = 18'd7; req0 = 1'b1;
        wait_for(0, 10, "t1_gnt0_timeout");
        #1 req0 = 1'b0;
        wait_for(2, 10, "t1_done0_timeout");
        check("t1_result", 32'(result), 32'(12));
        step(2);

        // Carry-out kept.
        a1 = MAXV; b1 = 18'd1; req1 = 1'b1;
        wait_for(1, 10, "t2_gnt1_timeout");
        #1 req1 = 1'b0;
        wait_for(3, 10, "t2_done1_timeout");
        check("t2_result_carry", 32'(result), 32'h40000);
        step(2);
        a1 = MAXV; b1 = MAXV; req1 = 1'b1;
        wait_for(1, 10, "t2b_gnt1_timeout");
        #1 req1 = 1'b0;
        wait_for(3, 10, "t2b_done1_timeout");
        check("t2_result_max", 32'(result), 32'h7FFFE);

        // Both requesting continuously: alternation starting with 0.
        do_reset();
        a0 = 18'd3; b0 = 18'd4; a1 = 18'd10; b1 = 18'd20;
        req0 = 1'b1; req1 = 1'b1;
        wait_for(2, 12, "t3_first_timeout");
        check("t3_first", 32'(result), 32'(7));
        wait_for(3, 12, "t3_second_timeout");
        check("t3_second", 32'(result), 32'(30));
        wait_for(2, 12, "t3_third_timeout");
        check("t3_third", 32'(result), 32'(7));
        #1 req0 = 1'b0; req1 = 1'b0;
        step(6);

        // Late request while busy is held off until IDLE.
        do_reset();
        req0 = 1'b1;
        wait_for(0, 10, "t4_gnt0_timeout");
        #1 req0 = 1'b0;
        step(1);
        req1 = 1'b1;
        wait_for(1, 12, "t4_gnt1_timeout");
        #1 req1 = 1'b0;
        wait_for(3, 10, "t4_done1_timeout");
        check("t4_result", 32'(result), 32'(30));
        step(2);

        // Reset during ADD with rr pointing at requester 1.
        req0 = 1'b1;
        wait_for(0, 10, "t5_gnt0_timeout");
        #1 req0 = 1'b0;
        wait_for(2, 10, "t5_done0_timeout");
        step(1);
        req1 = 1'b1;
        wait_for(1, 10, "t5_gnt1_timeout");
        #1 req1 = 1'b0;
        step(1);
        resetn = 1'b0;
        #1;
        check("t5_busy_async", 32'(busy), 32'(0));
        check("t5_result_async", 32'(result), 32'(0));
        check("t5_done_async", 32'({done0, done1}), 32'(0));
        #2 resetn = 1'b1;
        step(1);
        req0 = 1'b1; req1 = 1'b1;
        wait_for(4, 10, "t5_regrant_timeout");
        check("t5_regrant_is_0", 32'({gnt1, gnt0}), 32'(1));
        #1 req0 = 1'b0; req1 = 1'b0;
        step(6);

        // One-cycle req0 while busy is lost; one-cycle req0 in IDLE is served.
        req1 = 1'b1;
        wait_for(1, 10, "t6_gnt1_timeout");
        #1 req1 = 1'b0;
        step(1);
        req0 = 1'b1;
        step(1);
        req0 = 1'b0;
        gnt0_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (gnt0) gnt0_seen++;
        end
        check("t6_no_gnt0", 32'(gnt0_seen), 32'(0));
        #1 a0 = 18'd100; b0 = 18'd23; req0 = 1'b1;
        step(1);
        req0 = 1'b0;
        wait_for(2, 10, "t6_done0_timeout");
        check("t6_result", 32'(result), 32'(123));
        step(2);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin a0 = rand_op(); b0 = rand_op(); end
            if ($urandom_range(0, 3) == 0) begin a1 = rand_op(); b1 = rand_op(); end
            req0 = ($urandom_range(0, 2) != 0);
            req1 = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 199) == 0) resetn = 1'b0;
            else resetn = 1'b1;
            step(1);
        end
        resetn = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
